// File: rtl/fifo_pkg.sv
// Shared constants for the asynchronous FIFO and its read-side drain controller.
package fifo_pkg;

  localparam int WD         = 40;
  localparam int CW         = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // Occupancy arithmetic, widened to 3 bits so that add/sub never wraps.
  function automatic logic [2:0] occ_sum(input occ_t occ, input logic add, input logic sub);
    return 3'(occ) + 3'(add) - 3'(sub);
  endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Valid/ready output stream of the read-side drain controller.
interface fifo_rd_drain_if import fifo_pkg::*; #(parameter int wd = WD) ();

  logic          m_valid;
  logic [wd-1:0] m_data;
  logic          m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: absorbs words arriving one cycle after each FIFO
// read so that a stalled sink never causes a popped word to be lost.
module fifo_rd_skid import fifo_pkg::*; #(
  parameter int wd = WD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [wd-1:0] wr_data,
  output logic          valid,
  output logic [wd-1:0] data,
  input  logic          ready,
  output occ_t          occ
);

  logic          pop;
  logic [2:0]    occ_next;
  occ_t          slot;
  logic [wd-1:0] buf0, buf1;
  logic [wd-1:0] buf0_next, buf1_next;

  assign pop      = valid & ready;
  assign occ_next = occ_sum(occ, wr_valid, pop);
  // Slot index after any pop this cycle; the head has already moved forward.
  assign slot     = occ - occ_t'(pop);

  // Next buffer contents: shift on pop, then place the captured word.
  always_comb begin
    buf0_next = buf0;
    buf1_next = buf1;
    if (pop) begin
      buf0_next = buf1;
    end
    if (wr_valid) begin
      if (slot == 2'd0) begin
        buf0_next = wr_data;
      end else begin
        buf1_next = wr_data;
      end
    end
  end

  // Buffer and occupancy registers; reset is asserted high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      occ  <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ  <= occ_next[1:0];
      buf0 <= buf0_next;
      buf1 <= buf1_next;
    end
  end

  assign valid = (occ != 2'd0);
  assign data  = buf0;

  // The issue rule upstream keeps occupancy within the buffer depth.
  occ_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    occ_next <= 3'(SKID_DEPTH));

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side controller for the asynchronous FIFO, in the read-clock domain.
// Issues reads, absorbs the one-cycle read latency and delivers a valid/ready
// stream; also counts delivered words.
module fifo_rd_drain import fifo_pkg::*; #(
  parameter int wd = WD,
  parameter int cw = CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [wd-1:0]    fifo_rdata,
  fifo_rd_drain_if.master  m,
  output logic [cw-1:0]    word_cnt
);

  logic       pend;
  logic       pop;
  occ_t       occ;
  logic [2:0] committed;

  assign pop       = m.m_valid & m.m_ready;
  // Words buffered plus the one in flight, after this cycle's pop.
  assign committed = occ_sum(occ, pend, pop);
  assign fifo_rd_en = ~rst_n & enable & ~fifo_empty & (committed < 3'(SKID_DEPTH));

  // A read issued this cycle returns data next cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
    end
  end

  // Delivered-word counter, wrapping.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + cw'(1);
    end
  end

  fifo_rd_skid #(.wd(wd)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (pend),
    .wr_data  (fifo_rdata),
    .valid    (m.m_valid),
    .data     (m.m_data),
    .ready    (m.m_ready),
    .occ      (occ)
  );

endmodule
